fmc150_spi_arbiter: RTL and testbench

Shares the single FMC150 serial bus (common SCLK and SDO, a chip-select and SDI per device) among NREQ register-access clients, e.g. CDC and DAC.
- Arbitrates client requests round-robin.
- Serialises one frame at a time with guaranteed chip-select setup, hold and gap.
- Returns read-back data to the client it served.
- Sits between the FMC150 configuration workers in the FPGA top and the mezzanine pins, so no two device gates can ever overlap on the shared wires.

---
 rtl/fmc150_spi_pkg.sv | 22 ++
 rtl/fmc150_spi_shifter.sv | 103 ++++++++++
 rtl/fmc150_spi_arbiter.sv | 133 +++++++++++++
 tb/tb_fmc150_spi_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmc150_spi_pkg.sv
// Shared definitions for the FMC150 SPI arbiter: FSM states, datapath widths, nbits clamp.
// Readback is built only when FMC150_SPI_ARB_RDBACK_EN is defined.
package fmc150_spi_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned NBITS_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_t;

   // 0 and anything above 32 both mean a full 32-bit frame.
   function automatic logic [NBITS_W-1:0] clamp_nbits(input logic [NBITS_W-1:0] n);
      if (n == '0 || n > NBITS_W'(DATA_W)) return NBITS_W'(DATA_W);
      return n;
   endfunction

endpackage

// File: rtl/fmc150_spi_shifter.sv
// SCLK divider, bit counter and sdo/sdi shift registers for one SPI frame.
// The sdi capture register exists only when FMC150_SPI_ARB_RDBACK_EN is defined.
module fmc150_spi_shifter
   import fmc150_spi_pkg::*;
#(
   parameter int unsigned CLKDIV = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               load_i,
   input  logic               run_i,
   input  logic               shift_i,
   input  logic [DATA_W-1:0]  data_i,
   input  logic [NBITS_W-1:0] nbits_i,
   input  logic               sdi_i,
   output logic               tick_o,
   output logic               last_o,
   output logic               sclk_o,
   output logic               sdo_o,
   output logic [DATA_W-1:0]  rdata_o
);

   localparam int unsigned DIV_W = $clog2(CLKDIV);

   logic [DIV_W-1:0]   div_q;
   logic               phase_q;
   logic               sclk_q;
   logic               sdo_q;
   logic [NBITS_W-1:0] left_q;
   logic [DATA_W-1:0]  sr_q;
   logic [DATA_W-1:0]  aligned;

   // Frame is MSB-aligned so the next bit to send is always sr_q[DATA_W-1].
   assign aligned = data_i << (NBITS_W'(DATA_W) - nbits_i);
   assign tick_o  = (div_q == DIV_W'(CLKDIV - 1));
   assign last_o  = shift_i && tick_o && phase_q && (left_q == '0);
   assign sclk_o  = sclk_q;
   assign sdo_o   = sdo_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         div_q   <= '0;
         phase_q <= 1'b0;
         sclk_q  <= 1'b0;
         sdo_q   <= 1'b0;
         left_q  <= '0;
         sr_q    <= '0;
      end else if (load_i) begin
         div_q   <= '0;
         phase_q <= 1'b0;
         sclk_q  <= 1'b0;
         sdo_q   <= aligned[DATA_W-1];
         left_q  <= nbits_i - NBITS_W'(1);
         sr_q    <= aligned;
      end else if (!run_i) begin
         div_q   <= '0;
         phase_q <= 1'b0;
         sclk_q  <= 1'b0;
         sdo_q   <= 1'b0;
      end else if (!tick_o) begin
         div_q <= div_q + DIV_W'(1);
      end else begin
         div_q <= '0;
         if (shift_i) begin
            if (!phase_q) begin
               phase_q <= 1'b1;
               sclk_q  <= 1'b1;
            end else begin
               phase_q <= 1'b0;
               sclk_q  <= 1'b0;
               if (left_q == '0) begin
                  sdo_q <= 1'b0;
               end else begin
                  left_q <= left_q - NBITS_W'(1);
                  sr_q   <= sr_q << 1;
                  sdo_q  <= sr_q[DATA_W-2];
               end
            end
         end
      end
   end

`ifdef FMC150_SPI_ARB_RDBACK_EN
   logic [DATA_W-1:0] cap_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cap_q <= '0;
      end else if (load_i) begin
         cap_q <= '0;
      end else if (shift_i && tick_o && !phase_q) begin
         cap_q <= {cap_q[DATA_W-2:0], sdi_i};
      end
   end

   assign rdata_o = cap_q;
`else
   logic sdi_unused;
   assign sdi_unused = sdi_i;
   assign rdata_o    = '0;
`endif

endmodule

// File: rtl/fmc150_spi_arbiter.sv
// Round-robin arbiter sharing the FMC150 SPI bus between NREQ clients, one frame at a time.
// Define FMC150_SPI_ARB_RDBACK_EN to return captured sdi bits on rsp_data.
module fmc150_spi_arbiter
   import fmc150_spi_pkg::*;
#(
   parameter int unsigned NREQ   = 2,
   parameter int unsigned CLKDIV = 4,
   parameter int unsigned TGAP   = 8
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [DATA_W*NREQ-1:0]    req_data,
   input  logic [NBITS_W*NREQ-1:0]   req_nbits,
   output logic [NREQ-1:0]           rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      busy,
   output logic                      spi_sclk,
   output logic                      spi_sdo,
   output logic [NREQ-1:0]           spi_csb,
   input  logic [NREQ-1:0]           spi_sdi
);

   localparam int unsigned G_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned GAP_W = $clog2(TGAP + 1);

   state_t            state_q;
   logic [G_W-1:0]    g_q;
   logic [G_W-1:0]    ptr_q;
   logic [NREQ-1:0]   csb_q;
   logic              busy_q;
   logic [NREQ-1:0]   rsp_valid_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic [GAP_W-1:0]  gap_q;

   logic [G_W-1:0]    grant;
   logic [G_W-1:0]    cand;
   logic [NREQ-1:0]   grant_oh;
   logic              any_req;
   logic              accept;
   logic              tick;
   logic              last;
   logic [DATA_W-1:0] rdata;

   // Scan clients starting just after the last grant; the first valid one wins.
   always_comb begin
      grant   = ptr_q;
      cand    = ptr_q;
      any_req = 1'b0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = G_W'((32'(ptr_q) + k) % NREQ);
         if (!any_req && req_valid[cand]) begin
            any_req = 1'b1;
            grant   = cand;
         end
      end
      grant_oh = any_req ? (NREQ'(1) << grant) : '0;
   end

   assign accept    = (state_q == ST_IDLE) && any_req;
   assign req_ready = (state_q == ST_IDLE) ? grant_oh : '0;

   fmc150_spi_shifter #(
      .CLKDIV (CLKDIV)
   ) u_shifter (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .load_i  (accept),
      .run_i   (state_q == ST_SETUP || state_q == ST_SHIFT || state_q == ST_HOLD),
      .shift_i (state_q == ST_SHIFT),
      .data_i  (req_data[DATA_W*grant +: DATA_W]),
      .nbits_i (clamp_nbits(req_nbits[NBITS_W*grant +: NBITS_W])),
      .sdi_i   (spi_sdi[g_q]),
      .tick_o  (tick),
      .last_o  (last),
      .sclk_o  (spi_sclk),
      .sdo_o   (spi_sdo),
      .rdata_o (rdata)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         g_q         <= '0;
         ptr_q       <= G_W'(NREQ - 1);
         csb_q       <= '1;
         busy_q      <= 1'b0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         gap_q       <= '0;
      end else begin
         rsp_valid_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q <= ST_SETUP;
                  g_q     <= grant;
                  ptr_q   <= grant;
                  csb_q   <= ~grant_oh;
                  busy_q  <= 1'b1;
               end
            end
            ST_SETUP: if (tick) state_q <= ST_SHIFT;
            ST_SHIFT: if (last) state_q <= ST_HOLD;
            ST_HOLD: begin
               if (tick) begin
                  state_q          <= ST_GAP;
                  csb_q            <= '1;
                  rsp_valid_q[g_q] <= 1'b1;
                  rsp_data_q       <= rdata;
                  gap_q            <= '0;
               end
            end
            ST_GAP: begin
               if (gap_q == GAP_W'(TGAP - 1)) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  gap_q <= gap_q + GAP_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign spi_csb   = csb_q;
   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_fmc150_spi_arbiter.sv
// Self-checking bench for fmc150_spi_arbiter (NREQ=2, CLKDIV=4, TGAP=8); follows FMC150_SPI_ARB_RDBACK_EN.
module tb_fmc150_spi_arbiter;

   localparam int NREQ   = 2;
   localparam int CLKDIV = 4;
   localparam int TGAP   = 8;
`ifdef FMC150_SPI_ARB_RDBACK_EN
   localparam bit RDBACK = 1'b1;
`else
   localparam bit RDBACK = 1'b0;
`endif

   logic                 CLK = 1'b0;
   logic                 RST_N = 1'b0;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_ready;
   logic [32*NREQ-1:0]   req_data = '0;
   logic [6*NREQ-1:0]    req_nbits = '0;
   logic [NREQ-1:0]      rsp_valid;
   logic [31:0]          rsp_data;
   logic                 busy;
   logic                 spi_sclk;
   logic                 spi_sdo;
   logic [NREQ-1:0]      spi_csb;
   logic [NREQ-1:0]      spi_sdi;

   fmc150_spi_arbiter #(
      .NREQ   (NREQ),
      .CLKDIV (CLKDIV),
      .TGAP   (TGAP)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_nbits (req_nbits),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .spi_sclk  (spi_sclk),
      .spi_sdo   (spi_sdo),
      .spi_csb   (spi_csb),
      .spi_sdi   (spi_sdi)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int exp_last = NREQ - 1;

   always @(posedge CLK) cyc <= cyc + 1;

   // Bus monitor, sampled on the falling edge.
   int          acc_cyc[$];
   int          acc_idx[$];
   int          rsp_cyc[$];
   int          rsp_idx[$];
   logic [31:0] rsp_dat[$];
   int          rises = 0;
   logic [31:0] sdo_word = '0;
   logic [1:0]  low_mask = '0;
   int          low_cnt = 0;
   int          overlap_err = 0;
   int          sdo_err = 0;
   int          hi_run = 0;
   int          min_gap = 1000000;
   int          frames_seen = 0;
   logic        prev_low = 1'b0;
   logic        prev_sclk = 1'b0;
   int          rises_d[NREQ];

   // Device model: each device shifts out its word MSB first, advancing after each sclk rise.
   logic [31:0] sdi_word[NREQ];
   int          sdi_n[NREQ];

   initial begin
      for (int d = 0; d < NREQ; d++) begin
         rises_d[d]  = 0;
         sdi_word[d] = '0;
         sdi_n[d]    = 0;
      end
   end

   always_comb begin
      spi_sdi = '0;
      for (int d = 0; d < NREQ; d++) begin
         if (!spi_csb[d] && rises_d[d] < sdi_n[d])
            spi_sdi[d] = sdi_word[d][sdi_n[d] - 1 - rises_d[d]];
      end
   end

   always @(negedge CLK) begin
      for (int d = 0; d < NREQ; d++) begin
         if (req_valid[d] && req_ready[d]) begin
            acc_cyc.push_back(cyc);
            acc_idx.push_back(d);
         end
         if (rsp_valid[d]) begin
            rsp_cyc.push_back(cyc);
            rsp_idx.push_back(d);
            rsp_dat.push_back(rsp_data);
         end
         if (spi_csb[d]) rises_d[d] = 0;
         else if (spi_sclk && !prev_sclk) rises_d[d] = rises_d[d] + 1;
      end
      if (spi_sclk && !prev_sclk) begin
         rises    = rises + 1;
         sdo_word = {sdo_word[30:0], spi_sdo};
      end
      prev_sclk = spi_sclk;
      if (spi_csb == '0) overlap_err = overlap_err + 1;
      if (spi_csb != '1) begin
         low_cnt  = low_cnt + 1;
         low_mask = low_mask | ~spi_csb;
         if (!prev_low && frames_seen > 0 && hi_run < min_gap) min_gap = hi_run;
         hi_run   = 0;
         prev_low = 1'b1;
      end else begin
         if (spi_sdo !== 1'b0) sdo_err = sdo_err + 1;
         if (prev_low) frames_seen = frames_seen + 1;
         hi_run   = hi_run + 1;
         prev_low = 1'b0;
      end
   end

   function automatic logic [31:0] low_mask_of(input int n);
      return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
   endfunction

   // Drives one request from client c and collects what the bus monitor saw for that frame.
   task automatic do_frame(input int c, input logic [31:0] d, input logic [5:0] nb,
                           output int t_acc, output int a_idx, output int t_rsp, output int r_idx,
                           output logic [31:0] rdat, output logic [31:0] sword, output int nr,
                           output int lowc, output logic [1:0] lmask, output bit to);
      int w;
      to = 1'b0; t_acc = -1; a_idx = -1; t_rsp = -1; r_idx = -1;
      rdat = 'x; sword = 'x; nr = -1; lowc = -1; lmask = 'x;
      @(posedge CLK); #1;
      acc_cyc.delete(); acc_idx.delete();
      rsp_cyc.delete(); rsp_idx.delete(); rsp_dat.delete();
      rises = 0; sdo_word = '0; low_mask = '0; low_cnt = 0;
      req_data[32*c +: 32] = d;
      req_nbits[6*c +: 6]  = nb;
      req_valid[c]         = 1'b1;
      w = 0;
      while (acc_cyc.size() == 0 && w < 100) begin @(negedge CLK); #1; w++; end
      if (acc_cyc.size() == 0) begin to = 1'b1; req_valid[c] = 1'b0; return; end
      t_acc = acc_cyc[0];
      a_idx = acc_idx[0];
      @(posedge CLK); #1;
      req_valid[c] = 1'b0;
      w = 0;
      while (rsp_cyc.size() == 0 && w < 400) begin @(negedge CLK); #1; w++; end
      if (rsp_cyc.size() == 0) begin to = 1'b1; return; end
      t_rsp = rsp_cyc[0];
      r_idx = rsp_idx[0];
      rdat  = rsp_dat[0];
      sword = sdo_word;
      nr    = rises;
      lowc  = low_cnt;
      lmask = low_mask;
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      req_valid = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b want 00", req_ready); else n_pass++;
      n_checks++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); else n_pass++;
      n_checks++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (spi_sclk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", spi_sclk); else n_pass++;
      n_checks++; if (spi_sdo !== 1'b0) $display("FAIL reset_sdo: got %b want 0", spi_sdo); else n_pass++;
      n_checks++; if (spi_csb !== 2'b11) $display("FAIL reset_csb: got %b want 11", spi_csb); else n_pass++;
      @(posedge CLK); #1;
      RST_N = 1'b1;
      exp_last = NREQ - 1;
   endtask

   task automatic test_single_write();
      int ta, ai, tr, ri, nr, lc; logic [31:0] rd, sw; logic [1:0] lm; bit to;
      sdi_word[0] = $urandom;
      sdi_n[0]    = 16;
      do_frame(0, 32'h0000_A5C3, 6'd16, ta, ai, tr, ri, rd, sw, nr, lc, lm, to);
      exp_last = 0;
      n_checks++;
      if (to) begin $display("FAIL single_timeout: frame did not complete"); return; end
      else n_pass++;
      n_checks++; if (ai !== 0) $display("FAIL single_grant: got %0d want 0", ai); else n_pass++;
      n_checks++; if (nr !== 16) $display("FAIL single_rises: got %0d want 16", nr); else n_pass++;
      n_checks++; if (sw !== 32'h0000_A5C3) $display("FAIL single_sdo: got %h want 0000a5c3", sw); else n_pass++;
      n_checks++; if (lc !== 136) $display("FAIL single_csb_low: got %0d want 136", lc); else n_pass++;
      n_checks++; if (lm !== 2'b01) $display("FAIL single_csb_mask: got %b want 01", lm); else n_pass++;
      n_checks++; if (ri !== 0) $display("FAIL single_rsp_idx: got %0d want 0", ri); else n_pass++;
      n_checks++; if (tr - ta !== 137) $display("FAIL single_rsp_time: got %0d want 137", tr - ta); else n_pass++;
   endtask

   task automatic test_readback();
      int ta, ai, tr, ri, nr, lc; logic [31:0] rd, sw, exp_rd; logic [1:0] lm; bit to;
      sdi_word[1] = {$urandom_range(0, 65535), 16'h1234};
      sdi_n[1]    = 16;
      exp_rd      = RDBACK ? 32'h0000_1234 : 32'h0;
      do_frame(1, $urandom, 6'd16, ta, ai, tr, ri, rd, sw, nr, lc, lm, to);
      exp_last = 1;
      n_checks++;
      if (to) begin $display("FAIL readback_timeout: frame did not complete"); return; end
      else n_pass++;
      n_checks++; if (ri !== 1) $display("FAIL readback_rsp_idx: got %0d want 1", ri); else n_pass++;
      n_checks++; if (rd !== exp_rd) $display("FAIL readback_data: got %h want %h", rd, exp_rd); else n_pass++;
      n_checks++; if (lm !== 2'b10) $display("FAIL readback_csb_mask: got %b want 10", lm); else n_pass++;
      n_checks++; if (tr - ta !== 137) $display("FAIL readback_rsp_time: got %0d want 137", tr - ta); else n_pass++;
   endtask

   task automatic test_clamp();
      int ta, ai, tr, ri, nr, lc; logic [31:0] rd, sw, d, exp_rd; logic [1:0] lm; bit to;
      logic [5:0] nbs[2];
      nbs[0] = 6'd0;
      nbs[1] = 6'd40;
      for (int i = 0; i < 2; i++) begin
         d           = $urandom | 32'h8000_0000;
         sdi_word[0] = $urandom;
         sdi_n[0]    = 32;
         exp_rd      = RDBACK ? sdi_word[0] : 32'h0;
         do_frame(0, d, nbs[i], ta, ai, tr, ri, rd, sw, nr, lc, lm, to);
         exp_last = 0;
         n_checks++;
         if (to) begin $display("FAIL clamp_timeout: nbits %0d", nbs[i]); continue; end
         else n_pass++;
         n_checks++; if (nr !== 32) $display("FAIL clamp_rises: nbits %0d got %0d want 32", nbs[i], nr); else n_pass++;
         n_checks++; if (sw !== d) $display("FAIL clamp_sdo: nbits %0d got %h want %h", nbs[i], sw, d); else n_pass++;
         n_checks++; if (tr - ta !== 265) $display("FAIL clamp_rsp_time: nbits %0d got %0d want 265", nbs[i], tr - ta); else n_pass++;
         n_checks++; if (rd !== exp_rd) $display("FAIL clamp_rdata: nbits %0d got %h want %h", nbs[i], rd, exp_rd); else n_pass++;
      end
   endtask

   task automatic test_random();
      int ta, ai, tr, ri, nr, lc, c, n; logic [31:0] rd, sw, d, m, exp_rd; logic [1:0] lm, exp_lm;
      logic [5:0] nb; bit to;
      for (int i = 0; i < 6; i++) begin
         c  = $urandom_range(0, NREQ - 1);
         d  = $urandom;
         nb = 6'($urandom_range(0, 63));
         n  = (nb == 0 || nb > 32) ? 32 : int'(nb);
         m  = low_mask_of(n);
         sdi_word[c] = $urandom;
         sdi_n[c]    = n;
         exp_rd = RDBACK ? (sdi_word[c] & m) : 32'h0;
         exp_lm = 2'(1 << c);
         do_frame(c, d, nb, ta, ai, tr, ri, rd, sw, nr, lc, lm, to);
         exp_last = c;
         n_checks++;
         if (to) begin $display("FAIL random_timeout: iter %0d", i); continue; end
         else n_pass++;
         n_checks++; if (ai !== c) $display("FAIL random_grant: iter %0d got %0d want %0d", i, ai, c); else n_pass++;
         n_checks++; if (nr !== n) $display("FAIL random_rises: iter %0d got %0d want %0d", i, nr, n); else n_pass++;
         n_checks++; if (sw !== (d & m)) $display("FAIL random_sdo: iter %0d got %h want %h", i, sw, d & m); else n_pass++;
         n_checks++; if (lc !== 2*CLKDIV*(n+1)) $display("FAIL random_csb_low: iter %0d got %0d want %0d", i, lc, 2*CLKDIV*(n+1)); else n_pass++;
         n_checks++; if (lm !== exp_lm) $display("FAIL random_csb_mask: iter %0d got %b want %b", i, lm, exp_lm); else n_pass++;
         n_checks++; if (ri !== c) $display("FAIL random_rsp_idx: iter %0d got %0d want %0d", i, ri, c); else n_pass++;
         n_checks++; if (tr - ta !== 2*CLKDIV*(n+1)+1) $display("FAIL random_rsp_time: iter %0d got %0d want %0d", i, tr - ta, 2*CLKDIV*(n+1)+1); else n_pass++;
         n_checks++; if (rd !== exp_rd) $display("FAIL random_rdata: iter %0d got %h want %h", i, rd, exp_rd); else n_pass++;
      end
   endtask

   task automatic test_contention();
      int w, expv, base_overlap;
      @(posedge CLK); #1;
      RST_N = 1'b0;
      @(posedge CLK); #1;
      RST_N = 1'b1;
      exp_last = NREQ - 1;
      for (int d = 0; d < NREQ; d++) begin
         req_data[32*d +: 32] = $urandom;
         req_nbits[6*d +: 6]  = 6'd8;
         sdi_n[d] = 8;
      end
      acc_cyc.delete(); acc_idx.delete();
      rsp_cyc.delete(); rsp_idx.delete(); rsp_dat.delete();
      min_gap = 1000000; frames_seen = 0; base_overlap = overlap_err;
      req_valid = 2'b11;
      for (int f = 0; f < 4; f++) begin
         w = 0;
         while (acc_cyc.size() <= f && w < 600) begin @(negedge CLK); #1; w++; end
         n_checks++;
         if (acc_cyc.size() <= f) begin
            $display("FAIL contention_timeout: accept %0d never came", f);
            req_valid = '0;
            return;
         end
         expv = (exp_last == 0) ? 1 : 0;
         if (acc_idx[f] !== expv) $display("FAIL contention_order: accept %0d got %0d want %0d", f, acc_idx[f], expv);
         else n_pass++;
         exp_last = expv;
         @(posedge CLK); #1;
         req_valid[acc_idx[f]] = 1'b0;
         if (f == 1) req_valid = 2'b11;
      end
      w = 0;
      while (rsp_cyc.size() < 4 && w < 600) begin @(negedge CLK); #1; w++; end
      n_checks++; if (rsp_cyc.size() !== 4) $display("FAIL contention_rsp_count: got %0d want 4", rsp_cyc.size()); else n_pass++;
      n_checks++; if (overlap_err - base_overlap !== 0) $display("FAIL contention_overlap: got %0d cycles want 0", overlap_err - base_overlap); else n_pass++;
      n_checks++; if (min_gap < TGAP) $display("FAIL contention_gap: got %0d want >= %0d", min_gap, TGAP); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int w, t;
      @(posedge CLK); #1;
      acc_cyc.delete(); acc_idx.delete();
      req_data[31:0] = $urandom;
      req_nbits[5:0] = 6'd16;
      req_valid[0]   = 1'b1;
      w = 0;
      while (acc_cyc.size() == 0 && w < 100) begin @(negedge CLK); #1; w++; end
      n_checks++;
      if (acc_cyc.size() == 0) begin
         $display("FAIL resetmid_timeout: no accept");
         req_valid = '0;
         return;
      end
      n_pass++;
      t = acc_cyc[0];
      exp_last = 0;
      @(posedge CLK); #1;
      req_valid = '0;
      rsp_cyc.delete(); rsp_idx.delete(); rsp_dat.delete();
      while (cyc < t + 40) @(negedge CLK);
      n_checks++; if (spi_csb !== 2'b10) $display("FAIL resetmid_pre_csb: got %b want 10", spi_csb); else n_pass++;
      #1 RST_N = 1'b0;
      @(negedge CLK);
      n_checks++; if (spi_csb !== 2'b11) $display("FAIL resetmid_csb: got %b want 11", spi_csb); else n_pass++;
      n_checks++; if (spi_sclk !== 1'b0) $display("FAIL resetmid_sclk: got %b want 0", spi_sclk); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL resetmid_busy: got %b want 0", busy); else n_pass++;
      #1 RST_N = 1'b1;
      exp_last = NREQ - 1;
      repeat (300) @(negedge CLK);
      n_checks++; if (rsp_cyc.size() !== 0) $display("FAIL resetmid_no_rsp: got %0d responses want 0", rsp_cyc.size()); else n_pass++;
      @(posedge CLK); #1;
      acc_cyc.delete(); acc_idx.delete();
      req_valid = 2'b11;
      w = 0;
      while (acc_cyc.size() == 0 && w < 100) begin @(negedge CLK); #1; w++; end
      n_checks++;
      if (acc_cyc.size() == 0) $display("FAIL resetmid_restart: no accept after reset");
      else if (acc_idx[0] !== 0) $display("FAIL resetmid_restart: got client %0d want 0", acc_idx[0]);
      else n_pass++;
      @(posedge CLK); #1;
      req_valid = '0;
      exp_last = 0;
      t = (acc_cyc.size() > 0) ? acc_cyc[0] : cyc;
      w = 0;
      while (rsp_cyc.size() == 0 && w < 400) begin @(negedge CLK); #1; w++; end
      n_checks++;
      if (rsp_cyc.size() == 0) $display("FAIL resetmid_rsp: no response after restart");
      else if (rsp_idx[0] !== 0 || rsp_cyc[0] - t !== 2*CLKDIV*17+1)
         $display("FAIL resetmid_rsp: got client %0d at +%0d want client 0 at +%0d", rsp_idx[0], rsp_cyc[0] - t, 2*CLKDIV*17+1);
      else n_pass++;
   endtask

   task automatic test_invariants();
      n_checks++; if (overlap_err !== 0) $display("FAIL inv_overlap: got %0d cycles want 0", overlap_err); else n_pass++;
      n_checks++; if (sdo_err !== 0) $display("FAIL inv_sdo_idle: got %0d cycles want 0", sdo_err); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_readback();
      test_clamp();
      test_random();
      test_contention();
      test_reset_mid();
      repeat (20) @(posedge CLK);
      test_invariants();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
